// File: rtl/pattern_gen_if.sv
// pattern_gen_if: groups the video timing inputs, pattern controls and colour/timing outputs of pattern_gen.
// Latency: none (wires only); the block behind the slave modport adds its own pipeline.
// Backpressure: none; the pixel stream is free-running, one pixel per clk.
interface pattern_gen_if;
   logic        hsync_in;
   logic        vsync_in;
   logic        de_in;
   logic [10:0] pos_x;
   logic [10:0] pos_y;
   logic [2:0]  pattern_sel;
   logic [17:0] solid_rgb;
   logic [5:0]  red;
   logic [5:0]  green;
   logic [5:0]  blue;
   logic        hsync_out;
   logic        vsync_out;
   logic        de_out;
   logic [20:0] video_data;

   // Timing source / stimulus side
   modport master (
      output hsync_in, vsync_in, de_in, pos_x, pos_y, pattern_sel, solid_rgb,
      input  red, green, blue, hsync_out, vsync_out, de_out, video_data
   );

   // Pattern generator side
   modport slave (
      input  hsync_in, vsync_in, de_in, pos_x, pos_y, pattern_sel, solid_rgb,
      output red, green, blue, hsync_out, vsync_out, de_out, video_data
   );
endinterface

// File: rtl/pattern_gen.sv
// pattern_gen: renders bars/solid/checker/h-ramp/v-ramp/crosshatch aligned to incoming video timing.
// Latency: fixed 2 clk from pos_x/pos_y/hsync_in/vsync_in/de_in to colour, syncs, de_out and video_data.
// Backpressure: none; one pixel per clk. Optional horizontal scrolling with macro PATTERN_GEN_SCROLL_EN.
module pattern_gen #(
   parameter int H_ACTIVE   = 1366,  // active pixels per line (< 2048)
   parameter int V_ACTIVE   = 768,   // active lines per frame (< 2048)
   parameter int CHECK_LOG2 = 5      // checker / crosshatch cell = 2^CHECK_LOG2 pixels (1..9)
) (
   input  logic         clk,
   input  logic         rst_n,
   pattern_gen_if.slave vif
);

   // A degenerate tiny H_ACTIVE would make the bar width zero; clamp to 1.
   localparam int          BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam logic [10:0] BAR_W11 = 11'(BAR_W);
   localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
   localparam logic [11:0] V_LIM   = 12'(V_ACTIVE);
   localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
   localparam logic [10:0] V_LAST  = 11'(V_ACTIVE - 1);
`ifdef PATTERN_GEN_SCROLL_EN
   localparam logic [10:0] H_SUB   = 11'(H_ACTIVE);
`endif

   // Frame-level control
   logic        vs_rise;
   logic        vs_prev_q,    vs_prev_d;
   logic [2:0]  active_sel_q, active_sel_d;
`ifdef PATTERN_GEN_SCROLL_EN
   logic [10:0] frame_cnt_q,  frame_cnt_d;
   logic [10:0] x_sum;
`endif

   // Stage 1: sampled coordinates, timing and solid colour
   logic [10:0] x1_q,  x1_d;     // raw pos_x, used by ramps and crosshatch
   logic [10:0] xs1_q, xs1_d;    // possibly scrolled x, used by bars and checker
   logic [10:0] y1_q,  y1_d;
   logic        de1_q, de1_d;
   logic        hs1_q, hs1_d;
   logic        vs1_q, vs1_d;
   logic        in_range1_q, in_range1_d;
   logic [17:0] solid1_q, solid1_d;

   // Stage 2: registered colour and timing (drive the outputs directly)
   logic [5:0]  red_q,   red_d;
   logic [5:0]  green_q, green_d;
   logic [5:0]  blue_q,  blue_d;
   logic        hs2_q,   hs2_d;
   logic        vs2_q,   vs2_d;
   logic        de2_q,   de2_d;

   // Pattern datapath temporaries
   logic [10:0] bar_div;
   logic [2:0]  bar_idx;
   logic [5:0]  pix_r, pix_g, pix_b;

   // Pattern latch on vsync rise, optional frame counter, and stage-1 capture of the pixel inputs
   always_comb begin
      vs_rise      = vif.vsync_in & ~vs_prev_q;
      vs_prev_d    = vif.vsync_in;
      active_sel_d = vs_rise ? vif.pattern_sel : active_sel_q;

      x1_d        = vif.pos_x;
      y1_d        = vif.pos_y;
      de1_d       = vif.de_in;
      hs1_d       = vif.hsync_in;
      vs1_d       = vif.vsync_in;
      solid1_d    = vif.solid_rgb;
      in_range1_d = ({1'b0, vif.pos_x} < H_LIM) && ({1'b0, vif.pos_y} < V_LIM);

`ifdef PATTERN_GEN_SCROLL_EN
      frame_cnt_d = vs_rise ? frame_cnt_q + 11'd1 : frame_cnt_q;
      // Single compare-subtract wrap back into the active width.
      x_sum       = vif.pos_x + frame_cnt_q;
      xs1_d       = ({1'b0, x_sum} >= H_LIM) ? x_sum - H_SUB : x_sum;
`else
      xs1_d       = vif.pos_x;
`endif
   end

   // Stage-2 pattern render: pick colour by active pattern, blank outside de or the active area
   always_comb begin
      bar_div = xs1_q / BAR_W11;
      bar_idx = (bar_div > 11'd7) ? 3'd7 : bar_div[2:0];
      pix_r   = '0;
      pix_g   = '0;
      pix_b   = '0;

      case (active_sel_q)
         3'd0: begin
            // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to inverted index bits.
            pix_g = {6{~bar_idx[2]}};
            pix_r = {6{~bar_idx[1]}};
            pix_b = {6{~bar_idx[0]}};
         end
         3'd1: begin
            {pix_g, pix_r, pix_b} = solid1_q;
         end
         3'd2: begin
            if ((xs1_q[CHECK_LOG2] ^ y1_q[CHECK_LOG2]) == 1'b0) begin
               pix_r = 6'd63;
               pix_g = 6'd63;
               pix_b = 6'd63;
            end
         end
         3'd3: begin
            pix_r = x1_q[10:5];
            pix_g = x1_q[10:5];
            pix_b = x1_q[10:5];
         end
         3'd4: begin
            pix_r = y1_q[9:4];
            pix_g = y1_q[9:4];
            pix_b = y1_q[9:4];
         end
         3'd5: begin
            if ((x1_q[CHECK_LOG2-1:0] == '0) || (y1_q[CHECK_LOG2-1:0] == '0) ||
                (x1_q == H_LAST) || (y1_q == V_LAST)) begin
               pix_r = 6'd63;
               pix_g = 6'd63;
               pix_b = 6'd63;
            end
         end
         default: begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
         end
      endcase

      if (!de1_q || !in_range1_q) begin
         pix_r = '0;
         pix_g = '0;
         pix_b = '0;
      end

      red_d   = pix_r;
      green_d = pix_g;
      blue_d  = pix_b;
      hs2_d   = hs1_q;
      vs2_d   = vs1_q;
      de2_d   = de1_q;
   end

   // All state clears asynchronously so outputs drop to zero the moment reset asserts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev_q    <= 1'b0;
         active_sel_q <= 3'd0;
`ifdef PATTERN_GEN_SCROLL_EN
         frame_cnt_q  <= 11'd0;
`endif
         x1_q         <= '0;
         xs1_q        <= '0;
         y1_q         <= '0;
         de1_q        <= 1'b0;
         hs1_q        <= 1'b0;
         vs1_q        <= 1'b0;
         in_range1_q  <= 1'b0;
         solid1_q     <= '0;
         red_q        <= '0;
         green_q      <= '0;
         blue_q       <= '0;
         hs2_q        <= 1'b0;
         vs2_q        <= 1'b0;
         de2_q        <= 1'b0;
      end else begin
         vs_prev_q    <= vs_prev_d;
         active_sel_q <= active_sel_d;
`ifdef PATTERN_GEN_SCROLL_EN
         frame_cnt_q  <= frame_cnt_d;
`endif
         x1_q         <= x1_d;
         xs1_q        <= xs1_d;
         y1_q         <= y1_d;
         de1_q        <= de1_d;
         hs1_q        <= hs1_d;
         vs1_q        <= vs1_d;
         in_range1_q  <= in_range1_d;
         solid1_q     <= solid1_d;
         red_q        <= red_d;
         green_q      <= green_d;
         blue_q       <= blue_d;
         hs2_q        <= hs2_d;
         vs2_q        <= vs2_d;
         de2_q        <= de2_d;
      end
   end

   assign vif.red        = red_q;
   assign vif.green      = green_q;
   assign vif.blue       = blue_q;
   assign vif.hsync_out  = hs2_q;
   assign vif.vsync_out  = vs2_q;
   assign vif.de_out     = de2_q;
   assign vif.video_data = {hs2_q, vs2_q, de2_q, green_q, red_q, blue_q};

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed vectors with hand-computed colours for pattern_gen at 1366x768, 32-pixel cells.
// Latency: every pixel is checked exactly 2 clk after it is driven.
// Backpressure: none; inputs are driven 1 ns after each rising edge and outputs sampled there too.
module tb_pattern_gen;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   pattern_gen_if vif ();

   pattern_gen #(
      .H_ACTIVE  (1366),
      .V_ACTIVE  (768),
      .CHECK_LOG2(5)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .vif  (vif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] col(input int r, input int g, input int b);
      return {14'b0, 6'(r), 6'(g), 6'(b)};
   endfunction

   function automatic logic [31:0] got_rgb();
      return {14'b0, vif.red, vif.green, vif.blue};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input int x, input int y);
      vif.hsync_in = 1'b0;
      vif.vsync_in = 1'b0;
      vif.de_in    = 1'b1;
      vif.pos_x    = 11'(x);
      vif.pos_y    = 11'(y);
   endtask

   task automatic new_frame(input logic [2:0] sel);
      vif.pattern_sel = sel;
      vif.de_in       = 1'b0;
      vif.vsync_in    = 1'b1;
      tick();
      vif.vsync_in    = 1'b0;
      tick();
   endtask

   task automatic pix_chk(input string tag, input int x, input int y,
                          input int r, input int g, input int b);
      set_pix(x, y);
      tick();
      tick();
      check(tag, got_rgb(), col(r, g, b));
   endtask

   initial begin
      rst_n           = 1'b0;
      vif.hsync_in    = 1'b0;
      vif.vsync_in    = 1'b0;
      vif.de_in       = 1'b0;
      vif.pos_x       = '0;
      vif.pos_y       = '0;
      vif.pattern_sel = 3'd0;
      vif.solid_rgb   = '0;
      repeat (3) tick();
      check("rst_video_data", 32'(vif.video_data), 32'd0);
      check("rst_de_out", 32'(vif.de_out), 32'd0);
      rst_n = 1'b1;

      // Bars straight out of reset, with exact 2-clk alignment
      set_pix(0, 0);
      tick();
      set_pix(1365, 0);
      tick();
      check("bar_white_x0", got_rgb(), col(63, 63, 63));
      tick();
      check("bar_clamp_black_x1365", got_rgb(), col(0, 0, 0));
      pix_chk("bar_yellow_x170", 170, 0, 63, 63, 0);
      check("video_data_yellow", 32'(vif.video_data),
            {11'b0, 1'b0, 1'b0, 1'b1, 6'd63, 6'd63, 6'd0});
      pix_chk("bar_green_x510", 510, 0, 0, 63, 0);
      pix_chk("bar_magenta_x680", 680, 0, 63, 0, 63);
      pix_chk("bar_blue_x1020", 1020, 0, 0, 0, 63);

      // Mid-frame select change must wait for the vsync rise
      vif.pattern_sel = 3'd2;
      pix_chk("midframe_sel_ignored", 510, 0, 0, 63, 0);
      vif.de_in    = 1'b0;
      vif.vsync_in = 1'b1;
      tick();
      vif.vsync_in = 1'b0;
      tick();
      check("vsync_out_delay", 32'(vif.vsync_out), 32'd1);
      tick();
      check("vsync_out_fall", 32'(vif.vsync_out), 32'd0);
      pix_chk("checker_black_x32_y0", 32, 0, 0, 0, 0);
      pix_chk("checker_white_x32_y32", 32, 32, 63, 63, 63);
      pix_chk("checker_black_x510", 510, 0, 0, 0, 0);

      // Solid colour, blanking and sync delay
      vif.solid_rgb = 18'h3F000;
      new_frame(3'd1);
      pix_chk("solid_green", 100, 200, 0, 63, 0);
      vif.solid_rgb = 18'h2A555;
      pix_chk("solid_mixed", 5, 5, 21, 42, 21);
      vif.de_in    = 1'b0;
      vif.hsync_in = 1'b1;
      tick();
      vif.hsync_in = 1'b0;
      tick();
      check("blank_rgb_zero", got_rgb(), 32'd0);
      check("hsync_out_delay", 32'(vif.hsync_out), 32'd1);
      check("de_out_low", 32'(vif.de_out), 32'd0);
      tick();
      check("hsync_out_fall", 32'(vif.hsync_out), 32'd0);
      pix_chk("out_of_range_x", 1366, 0, 0, 0, 0);
      pix_chk("out_of_range_y", 0, 768, 0, 0, 0);

      // Ramps, crosshatch and the unused selects
      new_frame(3'd3);
      pix_chk("hramp_x1365", 1365, 0, 42, 42, 42);
      pix_chk("hramp_x64", 64, 0, 2, 2, 2);
      new_frame(3'd4);
      pix_chk("vramp_y767", 0, 767, 47, 47, 47);
      new_frame(3'd5);
      pix_chk("xhatch_right_edge", 1365, 5, 63, 63, 63);
      pix_chk("xhatch_inside_black", 3, 5, 0, 0, 0);
      pix_chk("xhatch_grid_x64", 64, 5, 63, 63, 63);
      pix_chk("xhatch_bottom_edge", 3, 767, 63, 63, 63);
      new_frame(3'd6);
      pix_chk("pattern6_black", 0, 0, 0, 0, 0);

      // Asynchronous reset mid-line, release with vsync already high
      new_frame(3'd5);
      set_pix(0, 0);
      tick();
      tick();
      check("pre_reset_white", got_rgb(), col(63, 63, 63));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_video_data", 32'(vif.video_data), 32'd0);
      vif.pattern_sel = 3'd3;
      vif.vsync_in    = 1'b1;
      vif.de_in       = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      vif.vsync_in = 1'b0;
      set_pix(1365, 0);
      tick();
      check("post_reset_pipe_empty", got_rgb(), 32'd0);
      tick();
      check("post_reset_first_pixel", got_rgb(), col(42, 42, 42));
      check("post_reset_de_out", 32'(vif.de_out), 32'd1);

`ifdef PATTERN_GEN_SCROLL_EN
      // Frame counter scrolls bars; 2048 rises bring it back to zero
      rst_n           = 1'b0;
      vif.vsync_in    = 1'b0;
      vif.pattern_sel = 3'd0;
      tick();
      rst_n = 1'b1;
      tick();
      pix_chk("scroll_frame0", 1365, 0, 0, 0, 0);
      repeat (3) new_frame(3'd0);
      pix_chk("scroll_frame3_white", 1365, 0, 63, 63, 63);
      pix_chk("scroll_frame3_yellow", 167, 0, 63, 63, 0);
      repeat (2045) new_frame(3'd0);
      pix_chk("scroll_wrap_black", 1365, 0, 0, 0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1366, meaning active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 768, meaning active lines per frame.
REQ-003 SHALL have parameter CHECK_LOG2, default 5, meaning checker/crosshatch cell size of 2^CHECK_LOG2 pixels.
REQ-004 SHALL have port clk, input, 1, pixel clock; the only clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports hsync_in / vsync_in / de_in, input, 1 each, timing from the cycle generator (active-high sync).
REQ-007 SHALL have ports pos_x / pos_y, input, 11 each, current pixel coordinates.
REQ-008 SHALL have port pattern_sel, input, 3, requested pattern.
REQ-009 SHALL have port solid_rgb, input, 18, {green,red,blue} for the solid pattern.
REQ-010 SHALL have ports red / green / blue, output, 6 each, registered pixel colour.
REQ-011 SHALL have ports hsync_out / vsync_out / de_out, output, 1 each, timing delayed to align with colour.
REQ-012 SHALL have port video_data, output, 21, {hsync_out,vsync_out,de_out,green,red,blue} for the 7:1 serializer.

Function
REQ-013 SHALL have a fixed latency of 2 clk from pos_x/pos_y/syncs/de_in to all outputs; syncs and de pass through a matching 2-stage delay.
REQ-014 SHALL register pattern_sel into active_sel only on a vsync_in rising edge (0->1 versus previous cycle); mid-frame changes SHALL have no effect until the next frame.
REQ-015 SHALL output red=green=blue=0 whenever the delayed de is 0.
REQ-016 Pattern 0 (bars): index = min(x / (H_ACTIVE/8), 7); index 0..7 = white, yellow, cyan, green, magenta, red, blue, black; components 63 or 0.
REQ-017 Pattern 1 (solid): outputs solid_rgb, sampled along with the pixel coordinates.
REQ-018 Pattern 2 (checker): white (all 63) when x[CHECK_LOG2] XOR y[CHECK_LOG2] = 0, otherwise black.
REQ-019 Pattern 3 (h-ramp): red=green=blue = x[10:5], truncated to 6 bits.
REQ-020 Pattern 4 (v-ramp): red=green=blue = y[9:4].
REQ-021 Pattern 5 (crosshatch): white when x[CHECK_LOG2-1:0]=0, y[CHECK_LOG2-1:0]=0, x=H_ACTIVE-1 or y=V_ACTIVE-1; otherwise black.
REQ-022 Patterns 6 and 7 SHALL output black.
REQ-023 x SHALL equal pos_x, or the moving-offset x per REQ-029; y SHALL always equal pos_y; all arithmetic SHALL be 11-bit unsigned, wrapping at 2048.
REQ-024 Coordinates with pos_x >= H_ACTIVE or pos_y >= V_ACTIVE while de_in=1 SHALL be rendered as black.

Reset
REQ-025 On rst_n=0, all outputs, pipeline registers and delay stages SHALL clear to 0 immediately (asynchronously), including video_data.
REQ-026 On rst_n=0, active_sel SHALL reset to 0 (bars), and the stored previous vsync SHALL reset to 0.
REQ-027 Reset release mid-frame SHALL produce correct aligned output from the 3rd clk onward without waiting for a vsync; a vsync_in already high at release SHALL count as a rising edge.

Configuration
REQ-028 With macro PATTERN_GEN_SCROLL_EN defined, SHALL include an 11-bit frame counter incremented on each vsync_in rising edge (reset 0, wraps 2047->0).
REQ-029 With PATTERN_GEN_SCROLL_EN defined, patterns 0 and 2 SHALL use x = (pos_x + frame_cnt) mod H_ACTIVE, computed in one compare-subtract step; other patterns SHALL be unaffected.
REQ-030 Without PATTERN_GEN_SCROLL_EN, there SHALL be no frame counter and x = pos_x for all patterns; the remaining behaviour SHALL be identical.

Verification
REQ-031 Reset, sel=0, de_in=1, pos_x=0 then 1365 -> after 2 clk white (63,63,63), then black; pos_x=170 -> yellow (r=63,g=63,b=0).
REQ-032 sel changed 0->2 mid-frame -> output stays bars until the vsync_in rise; next frame x=32,y=0 -> black and x=32,y=32 -> white.
REQ-033 sel=1, solid_rgb=18'h3F000 -> green=63, red=0, blue=0; with de_in=0 -> all zeros, while hsync_out tracks hsync_in delayed 2 clk.
REQ-034 sel=3, pos_x=1365 -> all components 42; sel=4, pos_y=767 -> 47; sel=5, x=1365,y=5 -> white.
REQ-035 rst_n asserted mid-line -> outputs 0 within the same cycle (asynchronous); after release, the first valid pixel appears 2 clk later.
REQ-036 With PATTERN_GEN_SCROLL_EN, after 3 frames sel=0, pos_x=1365 -> x=2 -> white; after 2048 frames the counter wraps to 0.
